// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback arbiter: register-file geometry,
// the queued request record, and a one-hot register decoder.
package wb_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  function automatic logic [XLEN-1:0] onehot32(input logic [REG_AW-1:0] rd);
    logic [XLEN-1:0] v;
    v     = '0;
    v[rd] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of pipeline commit, long-latency result and register-file write signals.
// Forwarding ports exist only when WB_FWD_EN is defined.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic              a_valid;
  logic [REG_AW-1:0] a_rd;
  logic [XLEN-1:0]   a_data;
  logic              a_hold;
  logic              b_valid;
  logic              b_ready;
  logic [REG_AW-1:0] b_rd;
  logic [XLEN-1:0]   b_data;
  logic              reg_write;
  logic [REG_AW-1:0] WB_rd_addr;
  logic [XLEN-1:0]   WB_rd_data;
  logic [XLEN-1:0]   busy;
`ifdef WB_FWD_EN
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic              rs1_fwd_valid;
  logic [XLEN-1:0]   rs1_fwd_data;
  logic              rs2_fwd_valid;
  logic [XLEN-1:0]   rs2_fwd_data;

  modport master (output a_valid, a_rd, a_data, b_valid, b_rd, b_data, rs1_addr, rs2_addr,
                  input  a_hold, b_ready, reg_write, WB_rd_addr, WB_rd_data, busy,
                         rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data);
  modport slave  (input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, rs1_addr, rs2_addr,
                  output a_hold, b_ready, reg_write, WB_rd_addr, WB_rd_data, busy,
                         rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data);
`else
  modport master (output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
                  input  a_hold, b_ready, reg_write, WB_rd_addr, WB_rd_data, busy);
  modport slave  (input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
                  output a_hold, b_ready, reg_write, WB_rd_addr, WB_rd_data, busy);
`endif

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; also exposes which slots hold live
// entries and their destination registers so the top can build the busy map.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wb_req_t                      push_req,
  input  logic                         pop,
  output wb_req_t                      head,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [DEPTH-1:0][REG_AW-1:0] entry_rd
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t       mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;

  // Pointers carry an extra wrap bit: equal index with differing wrap means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_req;
    end
  end

  // A slot is live when its distance from the read pointer is below the fill count.
  always_comb begin
    logic [AW-1:0] offset;
    offset      = '0;
    entry_valid = '0;
    entry_rd    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = AW'(i) - rd_ptr[AW-1:0];
      entry_valid[i] = ({1'b0, offset} < count);
      entry_rd[i]    = mem[i].rd;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: pipeline commits win, queued long-latency
// results fill idle slots. Optional same-cycle forwarding under WB_FWD_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  wb_req_t                      a_req;
  wb_req_t                      b_req;
  wb_req_t                      head;
  wb_req_t                      sel;
  logic                         sel_valid;
  logic                         full;
  logic                         empty;
  logic                         push;
  logic                         pop;
  logic [DEPTH-1:0]             entry_valid;
  logic [DEPTH-1:0][REG_AW-1:0] entry_rd;
  logic                         reg_write;
  logic [REG_AW-1:0]            wb_addr;
  logic [XLEN-1:0]              wb_data;
  logic [CW-1:0]                starve_cnt;
  logic [XLEN-1:0]              busy_map;

  assign a_req.rd    = bus.a_rd;
  assign a_req.data  = bus.a_data;
  assign b_req.rd    = bus.b_rd;
  assign b_req.data  = bus.b_data;

  assign bus.b_ready = !full;
  assign push        = bus.b_valid && !full;
  assign pop         = !bus.a_valid && !empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_req    (b_req),
    .pop         (pop),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  assign sel_valid = bus.a_valid || !empty;
  assign sel       = bus.a_valid ? a_req : head;

  // x0 writes still occupy the slot and update addr/data, but never enable the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else begin
      reg_write <= sel_valid && (sel.rd != '0);
      if (sel_valid) begin
        wb_addr <= sel.rd;
        wb_data <= sel.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || empty || pop) begin
      starve_cnt <= '0;
    end else if (bus.a_valid && starve_cnt != CW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign bus.a_hold     = (starve_cnt == CW'(STARVE_MAX));
  assign bus.reg_write  = reg_write;
  assign bus.WB_rd_addr = wb_addr;
  assign bus.WB_rd_data = wb_data;

  // With forwarding, the write in the output stage is bypassed rather than stalled on.
  always_comb begin
    busy_map = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        busy_map = busy_map | onehot32(entry_rd[i]);
      end
    end
`ifndef WB_FWD_EN
    if (reg_write) begin
      busy_map = busy_map | onehot32(wb_addr);
    end
`endif
    busy_map[0] = 1'b0;
  end

  assign bus.busy = busy_map;

`ifdef WB_FWD_EN
  assign bus.rs1_fwd_valid = reg_write && (wb_addr == bus.rs1_addr) && (bus.rs1_addr != '0);
  assign bus.rs1_fwd_data  = wb_data;
  assign bus.rs2_fwd_valid = reg_write && (wb_addr == bus.rs2_addr) && (bus.rs2_addr != '0);
  assign bus.rs2_fwd_data  = wb_data;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (DEPTH=4, STARVE_MAX=8); forwarding checks
// are included when WB_FWD_EN is defined.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  wb_arbiter_if bus ();

  wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                               input logic bv, input logic [4:0] brd, input logic [31:0] bd);
    bus.a_valid = av;
    bus.a_rd    = ard;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_rd    = brd;
    bus.b_data  = bd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkWrite(input string tag, input logic [4:0] rd, input logic [31:0] data);
    checkOutput({tag, "_we"}, {31'b0, bus.reg_write}, 32'd1);
    checkOutput({tag, "_addr"}, {27'b0, bus.WB_rd_addr}, {27'b0, rd});
    checkOutput({tag, "_data"}, bus.WB_rd_data, data);
  endtask

  // The pipeline must never commit to a register with a write still in flight.
  always @(negedge clk) begin
    if (!rst && bus.a_valid) begin
      checkOutput("order_contract", {31'b0, bus.busy[bus.a_rd]}, 32'd0);
    end
  end

  initial begin
    logic [4:0]  ard;
    logic [31:0] ad;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
`ifdef WB_FWD_EN
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;
`endif

    // Reset with both sources active
    rst = 1'b1;
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    tick();
    checkOutput("rst_we", {31'b0, bus.reg_write}, 32'd0);
    checkOutput("rst_busy", bus.busy, 32'd0);
    checkOutput("rst_hold", {31'b0, bus.a_hold}, 32'd0);
    tick();
    checkOutput("rst_we2", {31'b0, bus.reg_write}, 32'd0);
    checkOutput("rst_busy2", bus.busy, 32'd0);
    checkOutput("rst_addr", {27'b0, bus.WB_rd_addr}, 32'd0);
    checkOutput("rst_data", bus.WB_rd_data, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("rel_ready", {31'b0, bus.b_ready}, 32'd1);
    checkOutput("rel_we", {31'b0, bus.reg_write}, 32'd0);
    checkOutput("rel_busy", bus.busy, 32'd0);

    // B only: two-cycle latency, busy tracks the write
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    checkOutput("b_t1_we", {31'b0, bus.reg_write}, 32'd0);
    checkOutput("b_t1_busy", bus.busy, 32'h0000_0020);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkWrite("b_t2", 5'd5, 32'hDEADBEEF);
`ifdef WB_FWD_EN
    checkOutput("b_t2_busy", bus.busy, 32'h0000_0000);
`else
    checkOutput("b_t2_busy", bus.busy, 32'h0000_0020);
`endif
    tick();
    checkOutput("b_t3_we", {31'b0, bus.reg_write}, 32'd0);
    checkOutput("b_t3_busy", bus.busy, 32'd0);
    checkOutput("b_t3_addr_hold", {27'b0, bus.WB_rd_addr}, 32'd5);

    // Fill with A holding the port: x1..x4 enqueue, x5 waits, starvation builds
    for (int k = 1; k <= 9; k++) begin
      ard = (k % 2 == 0) ? 5'd20 : 5'd21;
      ad  = 32'hA000_0000 + 32'(k);
      applyStimulus(1'b1, ard, ad, 1'b1, (k <= 4) ? 5'(k) : 5'd5, 32'h100 + ((k <= 4) ? 32'(k) : 32'd5));
      tick();
      checkWrite("fill_a", ard, ad);
      if (k == 4) begin
        checkOutput("fill_full", {31'b0, bus.b_ready}, 32'd0);
`ifdef WB_FWD_EN
        checkOutput("fill_busy", bus.busy, 32'h0000_001E);
`else
        checkOutput("fill_busy", bus.busy, 32'h0010_001E);
`endif
      end
      if (k == 8) checkOutput("hold_pre", {31'b0, bus.a_hold}, 32'd0);
      if (k == 9) checkOutput("hold_set", {31'b0, bus.a_hold}, 32'd1);
    end

    // Pipeline bubbles: drain in order, x5 slips in behind
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h105);
    tick();
    checkWrite("drain1", 5'd1, 32'h101);
    checkOutput("hold_clr", {31'b0, bus.a_hold}, 32'd0);
    checkOutput("drain_ready", {31'b0, bus.b_ready}, 32'd1);
    tick();
    checkWrite("drain2", 5'd2, 32'h102);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkWrite("drain3", 5'd3, 32'h103);
    tick();
    checkWrite("drain4", 5'd4, 32'h104);
    tick();
    checkWrite("drain5", 5'd5, 32'h105);
    tick();
    checkOutput("drain_idle_we", {31'b0, bus.reg_write}, 32'd0);
    checkOutput("drain_idle_busy", bus.busy, 32'd0);

    // x0 handling on both sources
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("x0a_we", {31'b0, bus.reg_write}, 32'd0);
    checkOutput("x0a_data", bus.WB_rd_data, 32'h1234);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5555);
    tick();
    checkOutput("x0b_busy", bus.busy, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9999);
    tick();
    checkOutput("x0b_we", {31'b0, bus.reg_write}, 32'd0);
    checkOutput("x0b_busy2", bus.busy, 32'h0000_0200);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkWrite("x0b_next", 5'd9, 32'h9999);
    tick();

    // Wrap: continuous push/pop over 3*DEPTH entries
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'(8 + i), 32'hC0DE_0000 + 32'(i));
      tick();
      if (i >= 1) checkWrite("wrap", 5'(7 + i), 32'hC0DE_0000 + 32'(i - 1));
      if (i == 5) begin
`ifdef WB_FWD_EN
        checkOutput("wrap_busy", bus.busy, 32'h0000_2000);
`else
        checkOutput("wrap_busy", bus.busy, 32'h0000_3000);
`endif
      end
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkWrite("wrap_last", 5'd19, 32'hC0DE_000B);
    tick();
    checkOutput("wrap_idle_we", {31'b0, bus.reg_write}, 32'd0);
    checkOutput("wrap_ready", {31'b0, bus.b_ready}, 32'd1);

    // Forwarding of the write in the output stage
    applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkWrite("fwd_wr", 5'd7, 32'hA5A5A5A5);
`ifdef WB_FWD_EN
    bus.rs1_addr = 5'd7;
    bus.rs2_addr = 5'd0;
    #1;
    checkOutput("fwd_rs1_v", {31'b0, bus.rs1_fwd_valid}, 32'd1);
    checkOutput("fwd_rs1_d", bus.rs1_fwd_data, 32'hA5A5A5A5);
    checkOutput("fwd_rs2_v", {31'b0, bus.rs2_fwd_valid}, 32'd0);
    bus.rs1_addr = 5'd0;
`endif
    tick();

    // Mid-operation reset discards queued entries
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'h1111);
    tick();
    applyStimulus(1'b1, 5'd12, 32'h2222, 1'b1, 5'd13, 32'h3333);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    rst = 1'b0;
    checkOutput("mrst_busy", bus.busy, 32'd0);
    checkOutput("mrst_ready", {31'b0, bus.b_ready}, 32'd1);
    tick();
    checkOutput("mrst_we", {31'b0, bus.reg_write}, 32'd0);
    tick();
    checkOutput("mrst_we2", {31'b0, bus.reg_write}, 32'd0);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
